// File: rtl/dmem_responder.sv
// dmem_responder
// Word-organised data memory for the core's load/store port. Every request
// completes after WAIT_STATES wait cycles. Misaligned or out-of-range
// accesses complete with addr_fault and leave memory untouched.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   req          request valid (sampled in IDLE or RESP)
//   write_enable 1 = store, 0 = load (captured with req)
//   address      byte address (captured with req)
//   write_data   store data (captured with req)
//   read_data    load result, held between loads
//   ready        one-cycle completion pulse
//   busy         high while a request is in WAIT or RESP
//   addr_fault   pulses with ready when the completing request faulted
//   fault_count  saturating count of faulted requests
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy,
  output logic        addr_fault,
  output logic [7:0]  fault_count
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_L   = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        addr_fault_q, addr_fault_d;
  logic [7:0]  fault_count_q, fault_count_d;

  logic             enter_resp;
  logic             eff_we;
  logic [31:0]      eff_addr;
  logic [31:0]      eff_wdata;
  logic             fault;
  logic [IDX_W-1:0] idx;
  logic             mem_we;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (req) begin
          we_d    = write_enable;
          addr_d  = address;
          wdata_d = write_data;
          if (WAIT_STATES > 0) begin
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
          end else begin
            state_d = S_RESP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RESP always lasts one cycle, so any transition into RESP is a completion.
  // Coming from WAIT the latched request completes; otherwise (zero wait
  // states) the request being accepted at this very edge completes.
  always_comb begin
    enter_resp = (state_d == S_RESP);
    eff_we     = (state_q == S_WAIT) ? we_q    : write_enable;
    eff_addr   = (state_q == S_WAIT) ? addr_q  : address;
    eff_wdata  = (state_q == S_WAIT) ? wdata_q : write_data;
    fault      = (eff_addr[1:0] != 2'b00) || (eff_addr[31:2] >= DEPTH_L);
    idx        = eff_addr[IDX_W+1:2];
    mem_we     = enter_resp && eff_we && !fault && reset;
  end

  always_comb begin
    read_data_d   = read_data_q;
    ready_d       = enter_resp;
    busy_d        = (state_d != S_IDLE);
    addr_fault_d  = enter_resp && fault;
    fault_count_d = fault_count_q;
    if (enter_resp) begin
      if (fault) begin
        read_data_d   = 32'd0;
        fault_count_d = sat_inc8(fault_count_q);
      end else if (!eff_we) begin
        read_data_d = mem[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      read_data_q   <= 32'd0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      addr_fault_q  <= 1'b0;
      fault_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      read_data_q   <= read_data_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      addr_fault_q  <= addr_fault_d;
      fault_count_q <= fault_count_d;
    end
  end

  // Captured request fields only matter while a request is in flight.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= eff_wdata;
  end

  assign read_data   = read_data_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign addr_fault  = addr_fault_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int WS = 2;

  logic        clk;
  logic        reset;

  logic        req, write_enable;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready, busy, addr_fault;
  logic [7:0]  fault_count;

  logic        req_z, we_z;
  logic [31:0] addr_z, wd_z;
  logic [31:0] rd_z;
  logic        rdy_z, busy_z, af_z;
  logic [7:0]  fc_z;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .req(req), .write_enable(write_enable),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .busy(busy), .addr_fault(addr_fault), .fault_count(fault_count)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut_z (
    .clk(clk), .reset(reset), .req(req_z), .write_enable(we_z),
    .address(addr_z), .write_data(wd_z), .read_data(rd_z),
    .ready(rdy_z), .busy(busy_z), .addr_fault(af_z), .fault_count(fc_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        flt;
    logic [7:0]  fc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] sb_z[$];
  logic [31:0] mm [64];
  logic [31:0] mm_z [64];
  logic [31:0] exp_rd, exp_rd_z;
  logic [7:0]  exp_fc;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for the WAIT_STATES=2 instance.
  task automatic push_exp(input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic flt;
    flt = (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
    if (flt) begin
      exp_rd = 32'd0;
      exp_fc = (exp_fc == 8'hFF) ? 8'hFF : exp_fc + 8'd1;
    end else if (we) begin
      mm[a[7:2]] = d;
    end else begin
      exp_rd = mm[a[7:2]];
    end
    e.rd = exp_rd; e.flt = flt; e.fc = exp_fc;
    sb.push_back(e);
  endtask

  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   lat;
    @(negedge clk);
    req = 1'b1; write_enable = we; address = a; write_data = d;
    @(posedge clk);
    push_exp(we, a, d);
    lat = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      req = 1'b0;
      if (ready === 1'b1) begin
        lat = n;
        break;
      end
      check("busy_wait", {31'd0, busy}, 32'd1);
    end
    check("latency", 32'(lat), 32'(WS + 1));
    e = sb.pop_front();
    check("rdata", read_data, e.rd);
    check("fault", {31'd0, addr_fault}, {31'd0, e.flt});
    check("fcount", {24'd0, fault_count}, {24'd0, e.fc});
    check("busy_resp", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("ready_pulse", {31'd0, ready}, 32'd0);
  endtask

  initial begin
    exp_t        e;
    int          nrdy, first_rdy;
    logic [31:0] rd_cap;
    logic        flt_cap;

    reset = 1'b0;
    req = 1'b0; write_enable = 1'b0; address = '0; write_data = '0;
    req_z = 1'b0; we_z = 1'b0; addr_z = '0; wd_z = '0;
    exp_rd = '0; exp_rd_z = '0; exp_fc = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rdata", read_data, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fault", {31'd0, addr_fault}, 32'd0);
    check("rst_fcount", {24'd0, fault_count}, 32'd0);
    check("rst_z_busy", {31'd0, busy_z}, 32'd0);
    reset = 1'b1;

    // Word 5 gets known contents, then is read so read_data is non-zero
    do_req(1'b1, 32'h14, 32'h55AA0005);
    do_req(1'b0, 32'h14, 32'h0);

    // Reset in the middle of a store's WAIT drops the store
    @(negedge clk);
    req = 1'b1; write_enable = 1'b1; address = 32'h14; write_data = 32'hBAD00BAD;
    @(negedge clk);
    req = 1'b0;
    check("midwait_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_rdata", read_data, 32'd0);
    check("arst_ready", {31'd0, ready}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_fault", {31'd0, addr_fault}, 32'd0);
    check("arst_fcount", {24'd0, fault_count}, 32'd0);
    exp_rd = '0; exp_fc = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    do_req(1'b0, 32'h14, 32'h0);

    // Store then load with the default wait states
    do_req(1'b1, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 32'h10, 32'h0);

    // Misaligned store faults and leaves word 4 alone
    do_req(1'b1, 32'h13, 32'h12345678);
    do_req(1'b0, 32'h10, 32'h0);

    // Out-of-range load
    do_req(1'b0, 32'h100, 32'h0);

    // req pulsed with other address/data during WAIT is ignored
    do_req(1'b1, 32'h24, 32'h24242424);
    @(negedge clk);
    req = 1'b1; write_enable = 1'b1; address = 32'h20; write_data = 32'h11112222;
    @(posedge clk);
    push_exp(1'b1, 32'h20, 32'h11112222);
    nrdy = 0; first_rdy = 0; rd_cap = '0; flt_cap = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        nrdy++;
        if (first_rdy == 0) begin
          first_rdy = n; rd_cap = read_data; flt_cap = addr_fault;
        end
      end
      if (n == 1) begin
        address = 32'h24; write_data = 32'h99999999;
      end else begin
        req = 1'b0;
      end
    end
    e = sb.pop_front();
    check("ign_nready", 32'(nrdy), 32'd1);
    check("ign_latency", 32'(first_rdy), 32'(WS + 1));
    check("ign_rdata", rd_cap, e.rd);
    check("ign_fault", {31'd0, flt_cap}, {31'd0, e.flt});
    do_req(1'b0, 32'h20, 32'h0);
    do_req(1'b0, 32'h24, 32'h0);

    // Zero wait states: req held high, one completion per cycle
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        check("z_ready", {31'd0, rdy_z}, 32'd1);
        check("z_busy", {31'd0, busy_z}, 32'd1);
        check("z_rdata", rd_z, sb_z.pop_front());
      end
      if (k < 8) begin
        req_z = 1'b1; we_z = (k < 4); addr_z = 32'((k % 4) * 4);
        wd_z = 32'hA0000000 + 32'(k) * 32'h01010101;
        if (we_z) mm_z[addr_z[7:2]] = wd_z;
        else      exp_rd_z = mm_z[addr_z[7:2]];
        sb_z.push_back(exp_rd_z);
      end else begin
        req_z = 1'b0;
      end
      @(negedge clk);
    end
    check("z_idle_ready", {31'd0, rdy_z}, 32'd0);
    check("z_idle_busy", {31'd0, busy_z}, 32'd0);
    check("z_fcount", {24'd0, fc_z}, 32'd0);

    // Fault counter saturates at 255
    for (int i = 0; i < 300; i++) do_req(1'b0, 32'h100, 32'h0);
    check("sat_fcount", {24'd0, fault_count}, 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
